// File: rtl/dev_bridge_intc.sv
// dev_bridge_intc
// Bridge between the CPU data-memory port and the memory-mapped peripherals:
// two timer devices and an internal interrupt controller (INTC).
//
// Ports:
//   clk, reset            system clock; asynchronous active-high reset
//   cpu_addr/we/re/wd     CPU request (byte address, write strobe, read request, write data)
//   cpu_rd, cpu_rvalid    registered read data and its one-cycle valid pulse
//   dev_addr, dev_wd      address/data passthrough to the timers
//   dev0_we, dev1_we      per-timer write strobes (combinational)
//   dev0_rd, dev1_rd      timer read data (combinational from dev_addr[3:0])
//   irq_src               raw device interrupt lines
//   hwint, cpu_irq        masked pending vector and its OR, to CP0
//
// INTC register map (offset within INTC window):
//   0x0 PEND  pending[5:0], write-1-to-clear
//   0x4 MASK  [5:0] read/write
//   0x8 GEN   bit0 = global enable
//   0xC VEC   bit31 = any(pending & mask), [2:0] = lowest set index (read-only)

module dev_bridge_intc #(
  parameter logic [31:0] DEV0_BASE = 32'h0000_7f00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7f10,
  parameter logic [31:0] INTC_BASE = 32'h0000_7f20,
  parameter int          NIRQ      = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     cpu_addr,
  input  logic            cpu_we,
  input  logic            cpu_re,
  input  logic [31:0]     cpu_wd,
  output logic [31:0]     cpu_rd,
  output logic            cpu_rvalid,
  output logic [31:0]     dev_addr,
  output logic [31:0]     dev_wd,
  output logic            dev0_we,
  output logic            dev1_we,
  input  logic [31:0]     dev0_rd,
  input  logic [31:0]     dev1_rd,
  input  logic [NIRQ-1:0] irq_src,
  output logic [NIRQ-1:0] hwint,
  output logic            cpu_irq
);

  localparam logic [3:0] OFF_PEND = 4'h0;
  localparam logic [3:0] OFF_MASK = 4'h4;
  localparam logic [3:0] OFF_GEN  = 4'h8;
  localparam logic [3:0] OFF_VEC  = 4'hc;

  // State
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] mask_q,    mask_d;
  logic            gen_q,     gen_d;
  logic [NIRQ-1:0] irq_d_q;
  logic            capture_en_q;
  logic [31:0]     cpu_rd_q,  cpu_rd_d;
  logic            rvalid_q;

  // Decode
  logic       hit0, hit1, hit_c, intc_we;
  logic [3:0] off;

  assign hit0    = (cpu_addr[31:4] == DEV0_BASE[31:4]);
  assign hit1    = (cpu_addr[31:4] == DEV1_BASE[31:4]);
  assign hit_c   = (cpu_addr[31:4] == INTC_BASE[31:4]);
  assign off     = cpu_addr[3:0];
  assign intc_we = cpu_we & hit_c;

  assign dev_addr = cpu_addr;
  assign dev_wd   = cpu_wd;
  assign dev0_we  = cpu_we & hit0;
  assign dev1_we  = cpu_we & hit1;

  // Interrupt path
  logic [NIRQ-1:0] rise, w1c, masked;
  logic [2:0]      vec_idx;
  logic [31:0]     vec_word;
  logic [31:0]     rd_mux;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rise     = '0;
    w1c      = '0;
    vec_idx  = '0;
    pending_d = pending_q;
    mask_d   = mask_q;
    gen_d    = gen_q;

    // Capture is held off for the first clock after reset so irq_d first
    // tracks the live lines; a level already high at release is not an edge.
    if (capture_en_q) rise = irq_src & ~irq_d_q;

    if (intc_we && off == OFF_PEND) w1c    = cpu_wd[NIRQ-1:0];
    if (intc_we && off == OFF_MASK) mask_d = cpu_wd[NIRQ-1:0];
    if (intc_we && off == OFF_GEN)  gen_d  = cpu_wd[0];

    // Set is applied after the clear so a same-cycle edge wins.
    pending_d = (pending_q & ~w1c) | rise;

    // Lowest index has highest priority: scan downward, last hit wins.
    masked = pending_q & mask_q;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (masked[i]) vec_idx = 3'(i);
    end
    vec_word = {|masked, 28'd0, vec_idx};

    // Read mux uses current register values, so a simultaneous write
    // returns the pre-write contents.
    rd_mux = 32'd0;
    if (hit0)      rd_mux = dev0_rd;
    else if (hit1) rd_mux = dev1_rd;
    else if (hit_c) begin
      case (off)
        OFF_PEND: rd_mux = {{(32-NIRQ){1'b0}}, pending_q};
        OFF_MASK: rd_mux = {{(32-NIRQ){1'b0}}, mask_q};
        OFF_GEN:  rd_mux = {31'd0, gen_q};
        OFF_VEC:  rd_mux = vec_word;
        default:  rd_mux = 32'd0;
      endcase
    end

    cpu_rd_d = cpu_re ? rd_mux : cpu_rd_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q    <= '0;
      mask_q       <= '0;
      gen_q        <= 1'b0;
      irq_d_q      <= '0;
      capture_en_q <= 1'b0;
      cpu_rd_q     <= 32'd0;
      rvalid_q     <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      gen_q        <= gen_d;
      irq_d_q      <= irq_src;
      capture_en_q <= 1'b1;
      cpu_rd_q     <= cpu_rd_d;
      rvalid_q     <= cpu_re;
    end
  end

  assign cpu_rd     = cpu_rd_q;
  assign cpu_rvalid = rvalid_q;
  assign hwint      = gen_q ? (pending_q & mask_q) : '0;
  assign cpu_irq    = |hwint;

endmodule
